// File: rtl/quiz_pkg.sv
// Shared types and widths for the quiz round controller.
// Contents: FSM state encoding, BCD digit/score/count/round widths,
// and a clog2 helper that never returns less than 1.
package quiz_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned COUNT_W = 8;
  localparam int unsigned ROUND_W = 8;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_FETCH  = 3'd2,
    S_ANSWER = 3'd3,
    S_JUDGE  = 3'd4,
    S_RESULT = 3'd5
  } state_e;

  // Index width for n items, at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// Bus bundle between the quiz round controller and its surroundings.
// master: button block / question DB / display side (drives START, TICK,
//         Q_VALID, Q_ANS, P_*; observes everything else).
// slave : the controller (drives Q_REQ, STATE, COUNT, ENTRY, CURSOR,
//         LOCKED, WINNER, WIN_VALID, ROUND, SCORE).
interface quiz_round_ctrl_if
  import quiz_pkg::*;
#(
  parameter int unsigned DIGITS  = 6,
  parameter int unsigned PLAYERS = 2
);
  localparam int unsigned CW = clog2_min1(DIGITS);
  localparam int unsigned PW = clog2_min1(PLAYERS);

  logic                              START;
  logic                              TICK;
  logic                              Q_REQ;
  logic                              Q_VALID;
  logic [DIGIT_W*DIGITS-1:0]         Q_ANS;
  logic [PLAYERS-1:0]                P_SEL;
  logic [PLAYERS-1:0]                P_INC;
  logic [PLAYERS-1:0]                P_CLR;
  logic [PLAYERS-1:0]                P_DEC;
  logic [STATE_W-1:0]                STATE;
  logic [COUNT_W-1:0]                COUNT;
  logic [PLAYERS*DIGIT_W*DIGITS-1:0] ENTRY;
  logic [PLAYERS*CW-1:0]             CURSOR;
  logic [PLAYERS-1:0]                LOCKED;
  logic [PW-1:0]                     WINNER;
  logic                              WIN_VALID;
  logic [ROUND_W-1:0]                ROUND;
  logic [PLAYERS*SCORE_W-1:0]        SCORE;

  modport master (
    output START, TICK, Q_VALID, Q_ANS, P_SEL, P_INC, P_CLR, P_DEC,
    input  Q_REQ, STATE, COUNT, ENTRY, CURSOR, LOCKED, WINNER, WIN_VALID,
           ROUND, SCORE
  );

  modport slave (
    input  START, TICK, Q_VALID, Q_ANS, P_SEL, P_INC, P_CLR, P_DEC,
    output Q_REQ, STATE, COUNT, ENTRY, CURSOR, LOCKED, WINNER, WIN_VALID,
           ROUND, SCORE
  );

endinterface

// File: rtl/quiz_entry.sv
// One player's BCD answer entry channel.
// Ports: i_clk, i_rst (sync, active high); i_init clears for a new round;
// i_en enables input handling (ANSWER state); i_sel/i_inc/i_clr/i_dec are
// the player's pulses; i_ans is the latched expected answer.
// o_entry/o_cursor/o_locked are registered; o_match_c is the live compare.
module quiz_entry
  import quiz_pkg::*;
#(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned CW     = clog2_min1(DIGITS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_init,
  input  logic                      i_en,
  input  logic                      i_sel,
  input  logic                      i_inc,
  input  logic                      i_clr,
  input  logic                      i_dec,
  input  logic [DIGIT_W*DIGITS-1:0] i_ans,
  output logic [DIGIT_W*DIGITS-1:0] o_entry,
  output logic [CW-1:0]             o_cursor,
  output logic                      o_locked,
  output logic                      o_match_c
);

  localparam int unsigned EW = DIGIT_W * DIGITS;

  logic [EW-1:0] r_entry, w_entry_nxt;
  logic [CW-1:0] r_cursor, w_cursor_nxt;
  logic          r_locked, w_locked_nxt;

  assign o_match_c = (r_entry == i_ans);

  // Next entry/cursor/lock; CLR beats INC and SEL, INC uses the pre-move cursor.
  always_comb begin
    w_entry_nxt  = r_entry;
    w_cursor_nxt = r_cursor;
    w_locked_nxt = r_locked;
    if (i_init) begin
      w_entry_nxt  = '0;
      w_cursor_nxt = '0;
      w_locked_nxt = 1'b0;
    end else if (i_en && !r_locked) begin
      if (i_clr) begin
        w_entry_nxt  = '0;
        w_cursor_nxt = '0;
      end else begin
        if (i_inc) begin
          for (int d = 0; d < DIGITS; d++) begin
            if (r_cursor == CW'(d)) begin
              w_entry_nxt[d*DIGIT_W +: DIGIT_W] =
                (r_entry[d*DIGIT_W +: DIGIT_W] >= DIGIT_W'(9)) ? '0 :
                r_entry[d*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
            end
          end
        end
        if (i_sel) begin
          w_cursor_nxt = (r_cursor == CW'(DIGITS - 1)) ? '0 : r_cursor + CW'(1);
        end
      end
      if (i_dec && !o_match_c) w_locked_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_entry  <= '0;
      r_cursor <= '0;
      r_locked <= 1'b0;
    end else begin
      r_entry  <= w_entry_nxt;
      r_cursor <= w_cursor_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  assign o_entry  = r_entry;
  assign o_cursor = r_cursor;
  assign o_locked = r_locked;

endmodule

// File: rtl/quiz_round_ctrl.sv
// Multi-round, multi-player quiz controller: ready countdown, question
// fetch, per-player BCD entry, first-correct arbitration, scoring, result hold.
// Ports: CLK, RST (sync, active high); bus (quiz_round_ctrl_if.slave) carries
// START/TICK/Q_*/P_* inputs and all registered status outputs.
// Optional: define QUIZ_PENALTY_EN to subtract a point (floor 0) on a wrong submit.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int unsigned DIGITS     = 6,
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned ROUNDS     = 5,
  parameter int unsigned READY_SEC  = 3,
  parameter int unsigned ANSWER_SEC = 30,
  parameter int unsigned RESULT_SEC = 2
) (
  input  logic          CLK,
  input  logic          RST,
  quiz_round_ctrl_if.slave bus
);

  localparam int unsigned CW = clog2_min1(DIGITS);
  localparam int unsigned PW = clog2_min1(PLAYERS);
  localparam int unsigned EW = DIGIT_W * DIGITS;

  state_e                          r_state, w_state_nxt;
  logic [COUNT_W-1:0]              r_count, w_count_nxt;
  logic                            r_q_req, w_q_req_nxt;
  logic [EW-1:0]                   r_ans, w_ans_nxt;
  logic [PW-1:0]                   r_winner, w_winner_nxt;
  logic                            r_win_valid, w_win_valid_nxt;
  logic                            r_has_win, w_has_win_nxt;
  logic [ROUND_W-1:0]              r_round, w_round_nxt;
  logic [PLAYERS-1:0][SCORE_W-1:0] r_score, w_score_nxt;

  logic                 w_init, w_en;
  logic [PLAYERS-1:0]   w_match, w_locked, w_correct, w_wrong, w_lock_after;
  logic [PW-1:0]        w_first;
  logic [PLAYERS*EW-1:0] w_entry;
  logic [PLAYERS*CW-1:0] w_cursor;

  assign w_en = (r_state == S_ANSWER);

  // Per-player entry channels.
  for (genvar g = 0; g < PLAYERS; g++) begin : g_player
    quiz_entry #(.DIGITS(DIGITS), .CW(CW)) u_entry (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_init    (w_init),
      .i_en      (w_en),
      .i_sel     (bus.P_SEL[g]),
      .i_inc     (bus.P_INC[g]),
      .i_clr     (bus.P_CLR[g]),
      .i_dec     (bus.P_DEC[g]),
      .i_ans     (r_ans),
      .o_entry   (w_entry[g*EW +: EW]),
      .o_cursor  (w_cursor[g*CW +: CW]),
      .o_locked  (w_locked[g]),
      .o_match_c (w_match[g])
    );
  end

  // Classify this cycle's submits; lowest correct index wins.
  always_comb begin
    w_correct = '0;
    w_wrong   = '0;
    w_first   = '0;
    for (int i = 0; i < PLAYERS; i++) begin
      if (w_en && bus.P_DEC[i] && !w_locked[i]) begin
        if (w_match[i]) w_correct[i] = 1'b1;
        else            w_wrong[i]   = 1'b1;
      end
    end
    for (int i = PLAYERS - 1; i >= 0; i--) begin
      if (w_correct[i]) w_first = PW'(i);
    end
  end

  assign w_lock_after = w_locked | w_wrong;

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_q_req_nxt     = 1'b0;
    w_ans_nxt       = r_ans;
    w_winner_nxt    = r_winner;
    w_win_valid_nxt = r_win_valid;
    w_has_win_nxt   = r_has_win;
    w_round_nxt     = r_round;
    w_score_nxt     = r_score;
    w_init          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.START) begin
          w_state_nxt = S_READY;
          w_score_nxt = '0;
          w_round_nxt = ROUND_W'(1);
          w_count_nxt = COUNT_W'(READY_SEC);
        end
      end
      S_READY: begin
        if (bus.TICK) begin
          if (r_count == COUNT_W'(1)) begin
            w_state_nxt = S_FETCH;
            w_count_nxt = '0;
            w_q_req_nxt = 1'b1;
          end else if (r_count != '0) begin
            w_count_nxt = r_count - COUNT_W'(1);
          end
        end
      end
      S_FETCH: begin
        if (bus.Q_VALID) begin
          w_state_nxt     = S_ANSWER;
          w_ans_nxt       = bus.Q_ANS;
          w_count_nxt     = COUNT_W'(ANSWER_SEC);
          w_win_valid_nxt = 1'b0;
          w_init          = 1'b1;
        end
      end
      S_ANSWER: begin
        // A correct submit beats both lockout and timeout in the same cycle.
        if (|w_correct) begin
          w_state_nxt   = S_JUDGE;
          w_winner_nxt  = w_first;
          w_has_win_nxt = 1'b1;
          w_count_nxt   = '0;
        end else if (&w_lock_after ||
                     (bus.TICK && r_count == COUNT_W'(1))) begin
          w_state_nxt   = S_JUDGE;
          w_winner_nxt  = '0;
          w_has_win_nxt = 1'b0;
          w_count_nxt   = '0;
        end else if (bus.TICK && r_count != '0) begin
          w_count_nxt = r_count - COUNT_W'(1);
        end
`ifdef QUIZ_PENALTY_EN
        for (int i = 0; i < PLAYERS; i++) begin
          if (w_wrong[i] && r_score[i] != '0) w_score_nxt[i] = r_score[i] - SCORE_W'(1);
        end
`endif
      end
      S_JUDGE: begin
        w_state_nxt = S_RESULT;
        w_count_nxt = COUNT_W'(RESULT_SEC);
        if (r_has_win) begin
          w_win_valid_nxt = 1'b1;
          for (int i = 0; i < PLAYERS; i++) begin
            if (r_winner == PW'(i) && r_score[i] != '1) w_score_nxt[i] = r_score[i] + SCORE_W'(1);
          end
        end
      end
      S_RESULT: begin
        if (bus.START || (bus.TICK && r_count == COUNT_W'(1))) begin
          if (r_round == ROUND_W'(ROUNDS)) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
          end else begin
            w_state_nxt = S_READY;
            w_round_nxt = r_round + ROUND_W'(1);
            w_count_nxt = COUNT_W'(READY_SEC);
          end
        end else if (bus.TICK && r_count != '0) begin
          w_count_nxt = r_count - COUNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_q_req     <= 1'b0;
      r_ans       <= '0;
      r_winner    <= '0;
      r_win_valid <= 1'b0;
      r_has_win   <= 1'b0;
      r_round     <= '0;
      r_score     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_q_req     <= w_q_req_nxt;
      r_ans       <= w_ans_nxt;
      r_winner    <= w_winner_nxt;
      r_win_valid <= w_win_valid_nxt;
      r_has_win   <= w_has_win_nxt;
      r_round     <= w_round_nxt;
      r_score     <= w_score_nxt;
    end
  end

  assign bus.Q_REQ     = r_q_req;
  assign bus.STATE     = r_state;
  assign bus.COUNT     = r_count;
  assign bus.ENTRY     = w_entry;
  assign bus.CURSOR    = w_cursor;
  assign bus.LOCKED    = w_locked;
  assign bus.WINNER    = r_winner;
  assign bus.WIN_VALID = r_win_valid;
  assign bus.ROUND     = r_round;
  assign bus.SCORE     = r_score;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Self-checking bench for quiz_round_ctrl (DIGITS=6, PLAYERS=2, ROUNDS=2,
// default timing). Entry editing is table-driven; round flow, lockout,
// timeout, game end and mid-game reset are hand-written sequences.
module tb_quiz_round_ctrl;

  localparam int unsigned DIGITS  = 6;
  localparam int unsigned PLAYERS = 2;
  localparam int unsigned ROUNDS  = 2;
`ifdef QUIZ_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  quiz_round_ctrl_if #(.DIGITS(DIGITS), .PLAYERS(PLAYERS)) bus ();

  quiz_round_ctrl #(.DIGITS(DIGITS), .PLAYERS(PLAYERS), .ROUNDS(ROUNDS)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  inc;
    logic [1:0]  clr;
    logic [23:0] exp_e;
    logic [2:0]  exp_c;
  } vec_t;

  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.START = 1'b0; bus.TICK = 1'b0; bus.Q_VALID = 1'b0; bus.Q_ANS = '0;
    bus.P_SEL = '0; bus.P_INC = '0; bus.P_CLR = '0; bus.P_DEC = '0;
  endtask

  task automatic tick();
    bus.TICK = 1'b1; cyc(); bus.TICK = 1'b0;
  endtask

  task automatic start();
    bus.START = 1'b1; cyc(); bus.START = 1'b0;
  endtask

  task automatic pulse_inc(input logic [1:0] m, input int n);
    repeat (n) begin bus.P_INC = m; cyc(); end
    bus.P_INC = '0;
  endtask

  task automatic pulse_sel(input logic [1:0] m);
    bus.P_SEL = m; cyc(); bus.P_SEL = '0;
  endtask

  task automatic dec(input logic [1:0] m);
    bus.P_DEC = m; cyc(); bus.P_DEC = '0;
  endtask

  // Enter digits d2 d1 d0 (digit 0 first), leaving the cursor on digit 2.
  task automatic enter(input logic [1:0] m, input int d0, input int d1, input int d2);
    pulse_inc(m, d0); pulse_sel(m);
    pulse_inc(m, d1); pulse_sel(m);
    pulse_inc(m, d2);
  endtask

  task automatic addv(input logic [1:0] s, input logic [1:0] i, input logic [1:0] c,
                      input logic [23:0] e, input logic [2:0] cu);
    vec_t v;
    v.sel = s; v.inc = i; v.clr = c; v.exp_e = e; v.exp_c = cu;
    tbl.push_back(v);
  endtask

  // From READY with COUNT=3: count down, fetch question 143, land in ANSWER.
  task automatic go_answer(input string tag);
    tick(); tick(); tick();
    chk({tag, "_fetch_state"}, 64'(bus.STATE), 64'd2);
    chk({tag, "_qreq_hi"}, 64'(bus.Q_REQ), 64'd1);
    cyc();
    chk({tag, "_qreq_lo"}, 64'(bus.Q_REQ), 64'd0);
    bus.Q_VALID = 1'b1; bus.Q_ANS = 24'h000143;
    cyc();
    bus.Q_VALID = 1'b0; bus.Q_ANS = '0;
    chk({tag, "_ans_state"}, 64'(bus.STATE), 64'd3);
    chk({tag, "_ans_count"}, 64'(bus.COUNT), 64'd30);
    chk({tag, "_ans_entry"}, 64'(bus.ENTRY), 64'd0);
    chk({tag, "_ans_locked"}, 64'(bus.LOCKED), 64'd0);
    chk({tag, "_ans_winvalid"}, 64'(bus.WIN_VALID), 64'd0);
  endtask

  initial begin
    logic [15:0] exp_score;

    // Entry-editing vectors for player 0 (hand-computed).
    addv(2'b00, 2'b01, 2'b00, 24'h000001, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000002, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000003, 3'd0);
    addv(2'b01, 2'b00, 2'b00, 24'h000003, 3'd1);
    addv(2'b00, 2'b01, 2'b00, 24'h000013, 3'd1);
    addv(2'b00, 2'b01, 2'b00, 24'h000023, 3'd1);
    addv(2'b00, 2'b01, 2'b00, 24'h000033, 3'd1);
    addv(2'b00, 2'b01, 2'b00, 24'h000043, 3'd1);
    addv(2'b01, 2'b00, 2'b00, 24'h000043, 3'd2);
    addv(2'b01, 2'b00, 2'b00, 24'h000043, 3'd3);
    addv(2'b01, 2'b00, 2'b00, 24'h000043, 3'd4);
    addv(2'b01, 2'b00, 2'b00, 24'h000043, 3'd5);
    addv(2'b01, 2'b00, 2'b00, 24'h000043, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000044, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000045, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000046, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000047, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000048, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000049, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000040, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000041, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000042, 3'd0);
    addv(2'b00, 2'b01, 2'b00, 24'h000043, 3'd0);
    addv(2'b00, 2'b00, 2'b01, 24'h000000, 3'd0);
    addv(2'b01, 2'b01, 2'b00, 24'h000001, 3'd1);
    addv(2'b01, 2'b01, 2'b01, 24'h000000, 3'd0);

    // Reset state.
    clear_in();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_state", 64'(bus.STATE), 64'd0);
    chk("rst_count", 64'(bus.COUNT), 64'd0);
    chk("rst_qreq", 64'(bus.Q_REQ), 64'd0);
    chk("rst_score", 64'(bus.SCORE), 64'd0);
    chk("rst_round", 64'(bus.ROUND), 64'd0);

    // Game A, round 1.
    start();
    chk("a_ready_state", 64'(bus.STATE), 64'd1);
    chk("a_ready_count", 64'(bus.COUNT), 64'd3);
    chk("a_round1", 64'(bus.ROUND), 64'd1);
    go_answer("a1");

    for (int i = 0; i < tbl.size(); i++) begin
      bus.P_SEL = tbl[i].sel; bus.P_INC = tbl[i].inc; bus.P_CLR = tbl[i].clr;
      cyc();
      bus.P_SEL = '0; bus.P_INC = '0; bus.P_CLR = '0;
      chk($sformatf("vec%0d_entry0", i), 64'(bus.ENTRY[23:0]), 64'(tbl[i].exp_e));
      chk($sformatf("vec%0d_cursor0", i), 64'(bus.CURSOR[2:0]), 64'(tbl[i].exp_c));
    end
    chk("vec_entry1_idle", 64'(bus.ENTRY[47:24]), 64'd0);

    // Both players correct in the same cycle: player 0 wins.
    enter(2'b11, 3, 4, 1);
    chk("a1_both_entry", 64'(bus.ENTRY), 64'h000143_000143);
    dec(2'b11);
    chk("a1_judge_state", 64'(bus.STATE), 64'd4);
    chk("a1_winner", 64'(bus.WINNER), 64'd0);
    cyc();
    chk("a1_result_state", 64'(bus.STATE), 64'd5);
    chk("a1_winvalid", 64'(bus.WIN_VALID), 64'd1);
    chk("a1_score", 64'(bus.SCORE), 64'h0001);
    chk("a1_result_count", 64'(bus.COUNT), 64'd2);
    tick();
    chk("a1_result_count1", 64'(bus.COUNT), 64'd1);
    tick();
    chk("a2_ready_state", 64'(bus.STATE), 64'd1);
    chk("a2_round", 64'(bus.ROUND), 64'd2);
    chk("a2_ready_count", 64'(bus.COUNT), 64'd3);

    // Game A, round 2: START ignored in ANSWER, then timeout.
    go_answer("a2");
    start();
    chk("a2_start_ignored", 64'(bus.STATE), 64'd3);
    repeat (29) tick();
    chk("a2_count_last", 64'(bus.COUNT), 64'd1);
    chk("a2_still_answer", 64'(bus.STATE), 64'd3);
    tick();
    chk("a2_timeout_judge", 64'(bus.STATE), 64'd4);
    cyc();
    chk("a2_timeout_result", 64'(bus.STATE), 64'd5);
    chk("a2_timeout_winvalid", 64'(bus.WIN_VALID), 64'd0);
    tick(); tick();
    chk("a_end_idle", 64'(bus.STATE), 64'd0);
    chk("a_end_score", 64'(bus.SCORE), 64'h0001);

    // Game B, round 1: player 1 wins alone, START skips the hold.
    start();
    chk("b_score_clear", 64'(bus.SCORE), 64'd0);
    chk("b_round1", 64'(bus.ROUND), 64'd1);
    go_answer("b1");
    enter(2'b10, 3, 4, 1);
    dec(2'b10);
    chk("b1_winner", 64'(bus.WINNER), 64'd1);
    cyc();
    chk("b1_winvalid", 64'(bus.WIN_VALID), 64'd1);
    chk("b1_score", 64'(bus.SCORE), 64'h0100);
    start();
    chk("b1_skip_state", 64'(bus.STATE), 64'd1);
    chk("b1_skip_round", 64'(bus.ROUND), 64'd2);

    // Game B, round 2: lockout of both players.
    go_answer("b2");
    enter(2'b10, 2, 4, 1);
    dec(2'b10);
    exp_score = PEN ? 16'h0000 : 16'h0100;
    chk("b2_lock1", 64'(bus.LOCKED), 64'b10);
    chk("b2_lock1_state", 64'(bus.STATE), 64'd3);
    chk("b2_lock1_score", 64'(bus.SCORE), 64'(exp_score));
    pulse_inc(2'b10, 1);
    chk("b2_locked_inc_ignored", 64'(bus.ENTRY[47:24]), 64'h000142);
    enter(2'b01, 2, 4, 1);
    dec(2'b01);
    chk("b2_alllocked_judge", 64'(bus.STATE), 64'd4);
    chk("b2_alllocked", 64'(bus.LOCKED), 64'b11);
    cyc();
    chk("b2_result_state", 64'(bus.STATE), 64'd5);
    chk("b2_winvalid", 64'(bus.WIN_VALID), 64'd0);
    chk("b2_score", 64'(bus.SCORE), 64'(exp_score));
    start();
    chk("b_end_idle", 64'(bus.STATE), 64'd0);
    chk("b_end_score", 64'(bus.SCORE), 64'(exp_score));

    // Game C: FETCH waits indefinitely, then reset mid-ANSWER.
    start();
    tick(); tick(); tick();
    repeat (5) cyc();
    chk("c_fetch_wait", 64'(bus.STATE), 64'd2);
    bus.Q_VALID = 1'b1; bus.Q_ANS = 24'h000143;
    cyc();
    bus.Q_VALID = 1'b0; bus.Q_ANS = '0;
    chk("c_answer", 64'(bus.STATE), 64'd3);
    pulse_inc(2'b01, 2);
    pulse_sel(2'b01);
    dec(2'b10);
    tick();
    chk("c_pre_entry", 64'(bus.ENTRY[23:0]), 64'h000002);
    chk("c_pre_cursor", 64'(bus.CURSOR[2:0]), 64'd1);
    chk("c_pre_locked", 64'(bus.LOCKED), 64'b10);
    chk("c_pre_count", 64'(bus.COUNT), 64'd29);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("c_rst_state", 64'(bus.STATE), 64'd0);
    chk("c_rst_count", 64'(bus.COUNT), 64'd0);
    chk("c_rst_entry", 64'(bus.ENTRY), 64'd0);
    chk("c_rst_cursor", 64'(bus.CURSOR), 64'd0);
    chk("c_rst_locked", 64'(bus.LOCKED), 64'd0);
    chk("c_rst_winner", 64'(bus.WINNER), 64'd0);
    chk("c_rst_winvalid", 64'(bus.WIN_VALID), 64'd0);
    chk("c_rst_round", 64'(bus.ROUND), 64'd0);
    chk("c_rst_score", 64'(bus.SCORE), 64'd0);
    chk("c_rst_qreq", 64'(bus.Q_REQ), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
